// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the rename register file: ROB tag width,
// architectural register count and the hard-wired zero register index.
package reg_rename_file_pkg;

  localparam int unsigned ROB_WIDTH_BIT = 4;
  localparam int unsigned REG_COUNT     = 32;
  localparam int unsigned REG_ID_W      = 5;
  localparam logic [REG_ID_W-1:0] X0    = '0;

endpackage

// File: rtl/reg_rename_file_operand_resolve.sv
// Resolves one source operand: committed value, ROB bypass value, or a
// pending dependency on the producing ROB tag.
module operand_resolve
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned ROB_W = ROB_WIDTH_BIT
) (
  input  logic             busy,
  input  logic [ROB_W-1:0] tag,
  input  logic [31:0]      value,
  input  logic             rob_ready,
  input  logic [31:0]      rob_val,
  output logic [31:0]      val,
  output logic             has_dep,
  output logic [ROB_W-1:0] dep
);

  // Select the operand source; a busy register is bypassed from the ROB when it has the result
  always_comb begin
    val     = value;
    has_dep = 1'b0;
    dep     = '0;
    if (busy) begin
      if (rob_ready) begin
        val = rob_val;
      end else begin
        val     = '0;
        has_dep = 1'b1;
        dep     = tag;
      end
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags. Takes ROB
// commits and tail renames, answers decoder source queries, and drops all
// rename state on a misprediction flush.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned ROB_W = ROB_WIDTH_BIT,
  parameter int unsigned NREG  = REG_COUNT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_flag,
  input  logic [4:0]       commit_reg_id,
  input  logic [31:0]      commit_val,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [4:0]       new_reg_id,
  input  logic [ROB_W-1:0] new_rob_id,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  output logic [ROB_W-1:0] rob_q1_id,
  input  logic             rob_q1_ready,
  input  logic [31:0]      rob_q1_val,
  output logic [ROB_W-1:0] rob_q2_id,
  input  logic             rob_q2_ready,
  input  logic [31:0]      rob_q2_val,
  output logic [31:0]      rs1_val,
  output logic             rs1_has_dep,
  output logic [ROB_W-1:0] rs1_dep,
  output logic [31:0]      rs2_val,
  output logic             rs2_has_dep,
  output logic [ROB_W-1:0] rs2_dep,
  output logic [5:0]       busy_cnt
);

  logic [31:0]      value_q [NREG];
  logic [31:0]      value_d [NREG];
  logic [ROB_W-1:0] tag_q   [NREG];
  logic [ROB_W-1:0] tag_d   [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [5:0]       busy_cnt_q;
  logic [5:0]       busy_cnt_d;

  logic commit_en;
  logic commit_hit;
  logic rename_en;
  logic cnt_inc;
  logic cnt_dec;

  // Next-state: flush drops renames, otherwise apply commit then rename (rename wins on the same register)
  always_comb begin
    value_d    = value_q;
    tag_d      = tag_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    commit_en  = (commit_reg_id != X0);
    rename_en  = (new_reg_id != X0);
    commit_hit = commit_en && busy_q[commit_reg_id] &&
                 (tag_q[commit_reg_id] == commit_rob_id);
    cnt_inc    = rename_en && !busy_q[new_reg_id];
    // A matching commit on a register that is re-renamed this cycle stays busy, so it does not decrement
    cnt_dec    = commit_hit && !(rename_en && (new_reg_id == commit_reg_id));
    if (clear_flag) begin
      busy_d     = '0;
      busy_cnt_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        tag_d[i] = '0;
      end
    end else begin
      if (commit_en) begin
        value_d[commit_reg_id] = commit_val;
        if (commit_hit) begin
          busy_d[commit_reg_id] = 1'b0;
        end
      end
      if (rename_en) begin
        busy_d[new_reg_id] = 1'b1;
        tag_d[new_reg_id]  = new_rob_id;
      end
      busy_cnt_d = busy_cnt_q + {5'b0, cnt_inc} - {5'b0, cnt_dec};
    end
  end

  // State registers: synchronous reset, hold while the pipeline is paused
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      for (int unsigned i = 0; i < NREG; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  assign rob_q1_id = tag_q[dec_rs1];
  assign rob_q2_id = tag_q[dec_rs2];
  assign busy_cnt  = busy_cnt_q;

  operand_resolve #(.ROB_W(ROB_W)) u_rs1 (
    .busy      (busy_q[dec_rs1] && (dec_rs1 != X0)),
    .tag       (tag_q[dec_rs1]),
    .value     (value_q[dec_rs1]),
    .rob_ready (rob_q1_ready),
    .rob_val   (rob_q1_val),
    .val       (rs1_val),
    .has_dep   (rs1_has_dep),
    .dep       (rs1_dep)
  );

  operand_resolve #(.ROB_W(ROB_W)) u_rs2 (
    .busy      (busy_q[dec_rs2] && (dec_rs2 != X0)),
    .tag       (tag_q[dec_rs2]),
    .value     (value_q[dec_rs2]),
    .rob_ready (rob_q2_ready),
    .rob_val   (rob_q2_val),
    .val       (rs2_val),
    .has_dep   (rs2_has_dep),
    .dep       (rs2_dep)
  );

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file with per-register rename tags for the Tomasulo core.
- Sits between the decoder and the reorder buffer.
- Accepts the ROB's commit writes and new-tail rename notifications.
- Issues rs1/rs2 dependency queries to the ROB, and returns the operand value or the producing ROB tag to the decoder.
- Flushes all rename state on ROB-signalled misprediction.

Parameters:
- ROB_W, default `ROB_WIDTH_BIT: width of a ROB index/tag.
- NREG, default 32: number of architectural registers; x0 is hard-wired zero.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  pause when low; all state holds
- clear_flag  input  1  ROB misprediction flush
- commit_reg_id  input  5  ROB commit destination; 0 means no commit
- commit_val  input  32  committed value
- commit_rob_id  input  ROB_W  ROB entry being committed
- new_reg_id  input  5  rd of the instruction being inserted at ROB tail; 0 means none
- new_rob_id  input  ROB_W  tail tag assigned to new_reg_id
- dec_rs1  input  5  decoder source register 1
- dec_rs2  input  5  decoder source register 2
- rob_q1_id  output  ROB_W  tag query to ROB for rs1
- rob_q1_ready  input  1  ROB reply: tag result available
- rob_q1_val  input  32  ROB reply value
- rob_q2_id, rob_q2_ready, rob_q2_val: same as the q1 ports, for rs2
- rs1_val  output  32  operand value when there is no dependency
- rs1_has_dep  output  1  operand still pending
- rs1_dep  output  ROB_W  producing ROB tag when pending
- rs2_val, rs2_has_dep, rs2_dep: same as the rs1 ports
- busy_cnt  output  6  number of registers currently renamed (debug/perf)

Behaviour:
- State per register: value[32], busy, tag[ROB_W].
- x0 is never written or renamed and always reads value 0, no dependency.
- Reset (rst_in=1 at posedge): all value, busy and tag cleared to 0; busy_cnt=0. As a result rs*_val=0, rs*_has_dep=0, rs*_dep=0, rob_q*_id=0.
- Priority at posedge: rst_in > !rdy_in (hold everything) > clear_flag > normal update.
- clear_flag cycle (rdy_in=1):
  - All busy and tag cleared; values retained.
  - Commit and rename inputs in this cycle are ignored (wrong-path).
- Normal cycle, commit:
  - If commit_reg_id!=0, value[commit_reg_id] <= commit_val.
  - If busy[r] and tag[r]==commit_rob_id, busy[r] <= 0.
  - If the tag does not match (newer rename outstanding), busy and tag are unchanged.
- Normal cycle, rename:
  - If new_reg_id!=0, busy <= 1 and tag <= new_rob_id.
  - Same register renamed and committed in the same cycle: value is written, rename wins (busy=1, tag=new_rob_id).
- Query path, combinational, zero latency. For rsX:
  - rob_qX_id = tag[dec_rsX].
  - dec_rsX==0 or !busy: val=value, has_dep=0, dep=0.
  - busy and rob_qX_ready: val=rob_qX_val, has_dep=0, dep=0. The ROB bypass covers same-cycle RS/LSB broadcast and same-cycle commit.
  - Otherwise: val=0, has_dep=1, dep=tag.
- Queries see pre-update state. An instruction whose rs equals its own rd reads the previous producer, never its own new tag.
- busy_cnt tracks set/clear each cycle: +1 on rename of a non-busy register, -1 on matching commit clear, net 0 when both hit the same register. Never exceeds 31.
- Values are written as given; no width arithmetic beyond 32-bit storage.

Decomposition:
- Shared package/const.v: `ROB_WIDTH_BIT, register-count constant, X0 index.
- One natural sub-module, `operand_resolve`, instantiated twice. It takes busy, tag, value and the ROB reply, and produces val/has_dep/dep.
- Storage and the update process stay in the top module.

Test Plan:
- Reset then query: dec_rs1=5, dec_rs2=0 -> rs1_val=0, rs1_has_dep=0, rs2_val=0, busy_cnt=0.
- Rename then query: cycle 1 new_reg_id=5, new_rob_id=3. Cycle 2 dec_rs1=5, rob_q1_ready=0 -> rob_q1_id=3, rs1_has_dep=1, rs1_dep=3, busy_cnt=1. With rob_q1_ready=1, rob_q1_val=0x1234 -> rs1_val=0x1234, has_dep=0.
- Stale commit: rename x7->tag2, then rename x7->tag6, then commit x7, tag2, value 0xAA. Value[7]=0xAA, busy stays 1, tag=6. Commit x7, tag6, value 0xBB -> busy 0, rs1_val=0xBB.
- Same-cycle commit and rename on x9: tag4 outstanding; commit tag4, value 0x55 together with rename x9->tag8. Result: value[9]=0x55, busy=1, tag=8, busy_cnt unchanged.
- Flush: x3, x4 renamed; assert clear_flag together with commit x3 and rename x10. All busy=0 and busy_cnt=0; x3 keeps its old value; x10 is not renamed.
- rdy_in low plus x0: with rdy_in=0, rename x2 and commit x2 -> no change. Commit x0, value 0xFFFF -> x0 still reads 0, no dependency.
